// File: rtl/layer_norm_row_sched_pkg.sv
// Shared types and constants for the layer-norm row sequencer.
package layer_norm_row_sched_pkg;

    localparam int unsigned D_MODEL     = 64;
    localparam int unsigned X_WIDTH     = 16;
    localparam int unsigned Y_WIDTH     = 16;
    localparam int unsigned X_FRAC      = 10;
    localparam int unsigned ADDR_WIDTH  = 8;
    localparam int unsigned ROWS_WIDTH  = 8;
    localparam int unsigned TIMEOUT_CYC = 4096;

    localparam int unsigned X_VEC_W = D_MODEL * X_WIDTH;
    localparam int unsigned Y_VEC_W = D_MODEL * Y_WIDTH;
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_REQ   = 3'd1,
        ST_RD_CAP   = 3'd2,
        ST_LN_START = 3'd3,
        ST_LN_WAIT  = 3'd4,
        ST_WR       = 3'd5,
        ST_FINISH   = 3'd6
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] src_base;
        logic [ADDR_WIDTH-1:0] dst_base;
        logic [ROWS_WIDTH-1:0] num_rows;
    } job_t;

    // Row address of the idx-th row from base, wrapping modulo the buffer depth.
    function automatic logic [ADDR_WIDTH-1:0] row_addr(input logic [ADDR_WIDTH-1:0] base,
                                                       input logic [ROWS_WIDTH-1:0] idx);
        return ADDR_WIDTH'(base + ADDR_WIDTH'(idx));
    endfunction

endpackage

// File: rtl/layer_norm_row_sched_if.sv
// Command, buffer and layer-norm handshake bundle of the row sequencer.
interface layer_norm_row_sched_if;
    import layer_norm_row_sched_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_src_base;
    logic [ADDR_WIDTH-1:0] cmd_dst_base;
    logic [ROWS_WIDTH-1:0] cmd_num_rows;

    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [X_VEC_W-1:0]    rd_data;

    logic [X_VEC_W-1:0]    ln_x_vector;
    logic                  ln_start;
    logic                  ln_busy;
    logic                  ln_done_valid;
    logic [Y_VEC_W-1:0]    ln_y_vector;

    logic                  wr_en;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [Y_VEC_W-1:0]    wr_data;

    logic                  busy;
    logic                  job_done;
    logic                  timeout_err;
    logic [ROWS_WIDTH-1:0] rows_done;

    // Environment side: controller, buffers and layer_norm_top.
    modport master (
        output cmd_valid, cmd_src_base, cmd_dst_base, cmd_num_rows,
        output rd_data, ln_busy, ln_done_valid, ln_y_vector, wr_ready,
        input  cmd_ready, rd_en, rd_addr, ln_x_vector, ln_start,
        input  wr_en, wr_addr, wr_data, busy, job_done, timeout_err, rows_done
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_src_base, cmd_dst_base, cmd_num_rows,
        input  rd_data, ln_busy, ln_done_valid, ln_y_vector, wr_ready,
        output cmd_ready, rd_en, rd_addr, ln_x_vector, ln_start,
        output wr_en, wr_addr, wr_data, busy, job_done, timeout_err, rows_done
    );

endinterface

// File: rtl/layer_norm_row_sched.sv
// Row sequencer: fetch x row, run layer_norm_top, write y row, one row in flight.
module layer_norm_row_sched
    import layer_norm_row_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    layer_norm_row_sched_if.slave  bus
);

    state_e                state_q, state_d;
    job_t                  job_q, job_d;
    logic [ROWS_WIDTH-1:0] row_idx_q, row_idx_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [X_VEC_W-1:0]    ln_x_q, ln_x_d;
    logic                  ln_start_q, ln_start_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [Y_VEC_W-1:0]    wr_data_q, wr_data_d;
    logic                  busy_q, busy_d;
    logic                  job_done_q, job_done_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [ROWS_WIDTH-1:0] rows_done_q, rows_done_d;

    // Next-state and registered-output decode; every strobe defaults low.
    always_comb begin
        state_d       = state_q;
        job_d         = job_q;
        row_idx_d     = row_idx_q;
        tmo_d         = tmo_q;
        rd_en_d       = 1'b0;
        rd_addr_d     = rd_addr_q;
        ln_x_d        = ln_x_q;
        ln_start_d    = 1'b0;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        job_done_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        rows_done_d   = rows_done_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    job_d         = '{src_base: bus.cmd_src_base,
                                      dst_base: bus.cmd_dst_base,
                                      num_rows: bus.cmd_num_rows};
                    row_idx_d     = '0;
                    rows_done_d   = '0;
                    timeout_err_d = 1'b0;
                    if (bus.cmd_num_rows == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d   = ST_RD_REQ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = bus.cmd_src_base;
                    end
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                // Buffer returns the row the cycle after rd_en.
                ln_x_d  = bus.rd_data;
                state_d = ST_LN_START;
            end
            ST_LN_START: begin
                if (!bus.ln_busy) begin
                    ln_start_d = 1'b1;
                    tmo_d      = '0;
                    state_d    = ST_LN_WAIT;
                end
            end
            ST_LN_WAIT: begin
                if (bus.ln_done_valid) begin
                    wr_data_d = bus.ln_y_vector;
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_addr(job_q.dst_base, row_idx_q);
                    state_d   = ST_WR;
                end else begin
                    tmo_d = TMO_W'(tmo_q + TMO_W'(1));
                    if (tmo_d == TMO_W'(TIMEOUT_CYC)) begin
                        timeout_err_d = 1'b1;
                        state_d       = ST_FINISH;
                    end
                end
            end
            ST_WR: begin
                if (bus.wr_ready) begin
                    rows_done_d = ROWS_WIDTH'(rows_done_q + ROWS_WIDTH'(1));
                    row_idx_d   = ROWS_WIDTH'(row_idx_q + ROWS_WIDTH'(1));
                    if (row_idx_d == job_q.num_rows) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d   = ST_RD_REQ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = row_addr(job_q.src_base, row_idx_d);
                    end
                end else begin
                    wr_en_d = 1'b1;
                end
            end
            ST_FINISH: begin
                job_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            job_q         <= '0;
            row_idx_q     <= '0;
            tmo_q         <= '0;
            cmd_ready_q   <= 1'b1;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            ln_x_q        <= '0;
            ln_start_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            job_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            rows_done_q   <= '0;
        end else begin
            state_q       <= state_d;
            job_q         <= job_d;
            row_idx_q     <= row_idx_d;
            tmo_q         <= tmo_d;
            cmd_ready_q   <= cmd_ready_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            ln_x_q        <= ln_x_d;
            ln_start_q    <= ln_start_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            job_done_q    <= job_done_d;
            timeout_err_q <= timeout_err_d;
            rows_done_q   <= rows_done_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_addr     = rd_addr_q;
    assign bus.ln_x_vector = ln_x_q;
    assign bus.ln_start    = ln_start_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.busy        = busy_q;
    assign bus.job_done    = job_done_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.rows_done   = rows_done_q;

endmodule

// File: tb/tb_layer_norm_row_sched.sv
// Directed bench: behavioural x/y buffers and a layer-norm stand-in around the sequencer.
module tb_layer_norm_row_sched;
    import layer_norm_row_sched_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    layer_norm_row_sched_if bus();

    layer_norm_row_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [X_VEC_W-1:0] xmem [256];

    // LN stand-in controls.
    logic        ln_done_en;
    int unsigned ln_lat;
    int unsigned ln_cnt;
    logic [X_VEC_W-1:0] ln_xs;

    // Observation logs.
    logic [ADDR_WIDTH-1:0] rd_log[$];
    logic [ADDR_WIDTH-1:0] wr_log[$];
    logic [Y_VEC_W-1:0]    wd_log[$];
    int ln_start_cnt = 0;
    int job_done_cnt = 0;

    // Snapshot bases for per-job deltas.
    int rb, wb, lb, jb;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [X_VEC_W-1:0] alt_row(input logic [15:0] a, input logic [15:0] b);
        logic [X_VEC_W-1:0] r = '0;
        for (int i = 0; i < int'(D_MODEL); i++)
            r[i*X_WIDTH +: X_WIDTH] = (i % 2 == 0) ? a : b;
        return r;
    endfunction

    function automatic int count_diff(input logic [Y_VEC_W-1:0] a, input logic [Y_VEC_W-1:0] b);
        int n = 0;
        for (int i = 0; i < int'(D_MODEL); i++)
            if (a[i*Y_WIDTH +: Y_WIDTH] !== b[i*Y_WIDTH +: Y_WIDTH]) n++;
        return n;
    endfunction

    function automatic int count_big(input logic [Y_VEC_W-1:0] y, input int tol);
        int n = 0;
        int v;
        for (int i = 0; i < int'(D_MODEL); i++) begin
            v = int'($signed(y[i*Y_WIDTH +: Y_WIDTH]));
            if (v > tol || v < -tol) n++;
        end
        return n;
    endfunction

    // Mean-centred, mean-absolute-deviation scaled row in Q5.10.
    function automatic logic [Y_VEC_W-1:0] ln_model(input logic [X_VEC_W-1:0] x);
        logic [Y_VEC_W-1:0] y = '0;
        int sum = 0;
        int mad = 0;
        int mean;
        int e;
        for (int i = 0; i < int'(D_MODEL); i++)
            sum += int'($signed(x[i*X_WIDTH +: X_WIDTH]));
        mean = sum / int'(D_MODEL);
        for (int i = 0; i < int'(D_MODEL); i++) begin
            e = int'($signed(x[i*X_WIDTH +: X_WIDTH])) - mean;
            mad += (e < 0) ? -e : e;
        end
        mad = mad / int'(D_MODEL);
        if (mad != 0)
            for (int i = 0; i < int'(D_MODEL); i++) begin
                e = int'($signed(x[i*X_WIDTH +: X_WIDTH])) - mean;
                y[i*Y_WIDTH +: Y_WIDTH] = Y_WIDTH'((e * 1024) / mad);
            end
        return y;
    endfunction

    // x buffer: registered read, data one cycle after rd_en.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= xmem[bus.rd_addr];
    end

    // Layer-norm stand-in: busy for ln_lat+1 cycles after start, optional done pulse.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ln_busy       <= 1'b0;
            bus.ln_done_valid <= 1'b0;
            bus.ln_y_vector   <= '0;
            ln_cnt            <= 0;
            ln_xs             <= '0;
        end else begin
            bus.ln_done_valid <= 1'b0;
            if (bus.ln_start && !bus.ln_busy) begin
                bus.ln_busy <= 1'b1;
                ln_cnt      <= ln_lat;
                ln_xs       <= bus.ln_x_vector;
            end else if (bus.ln_busy) begin
                if (ln_cnt == 0) begin
                    bus.ln_busy <= 1'b0;
                    if (ln_done_en) begin
                        bus.ln_done_valid <= 1'b1;
                        bus.ln_y_vector   <= ln_model(ln_xs);
                    end
                end else begin
                    ln_cnt <= ln_cnt - 1;
                end
            end
        end
    end

    // Monitor of reads, starts, accepted writes and job completions.
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.rd_en) rd_log.push_back(bus.rd_addr);
            if (bus.ln_start) ln_start_cnt++;
            if (bus.job_done) job_done_cnt++;
            if (bus.wr_en && bus.wr_ready) begin
                wr_log.push_back(bus.wr_addr);
                wd_log.push_back(bus.wr_data);
            end
        end
    end

    task automatic snap();
        rb = rd_log.size();
        wb = wr_log.size();
        lb = ln_start_cnt;
        jb = job_done_cnt;
    endtask

    task automatic send_cmd(input string tag, input logic [7:0] src, input logic [7:0] dst,
                            input logic [7:0] rows);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid    = 1'b1;
        bus.cmd_src_base = src;
        bus.cmd_dst_base = dst;
        bus.cmd_num_rows = rows;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!bus.job_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_job_done_seen"}, 64'(bus.job_done), 64'd1);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cmd_ready"},   64'(bus.cmd_ready),    64'd1);
        chk({tag, "_busy"},        64'(bus.busy),         64'd0);
        chk({tag, "_rd_en"},       64'(bus.rd_en),        64'd0);
        chk({tag, "_ln_start"},    64'(bus.ln_start),     64'd0);
        chk({tag, "_wr_en"},       64'(bus.wr_en),        64'd0);
        chk({tag, "_job_done"},    64'(bus.job_done),     64'd0);
        chk({tag, "_timeout_err"}, 64'(bus.timeout_err),  64'd0);
        chk({tag, "_rows_done"},   64'(bus.rows_done),    64'd0);
        chk({tag, "_rd_addr"},     64'(bus.rd_addr),      64'd0);
        chk({tag, "_wr_addr"},     64'(bus.wr_addr),      64'd0);
        chk({tag, "_ln_x_nz"},     64'(|bus.ln_x_vector), 64'd0);
        chk({tag, "_wr_data_nz"},  64'(|bus.wr_data),     64'd0);
    endtask

    initial begin
        logic [Y_VEC_W-1:0] y_a;
        logic [Y_VEC_W-1:0] y_b;
        logic [ADDR_WIDTH-1:0] sa;
        logic [Y_VEC_W-1:0] sd;
        int n;

        bus.cmd_valid    = 1'b0;
        bus.cmd_src_base = '0;
        bus.cmd_dst_base = '0;
        bus.cmd_num_rows = '0;
        bus.wr_ready     = 1'b1;
        ln_done_en       = 1'b1;
        ln_lat           = 5;
        for (int i = 0; i < 256; i++) xmem[i] = '0;
        y_a = alt_row(16'h0400, 16'hFC00);
        y_b = alt_row(16'hFC00, 16'h0400);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single constant row normalises to ~0.
        xmem[0] = alt_row(16'h0400, 16'h0400);
        snap();
        send_cmd("t1", 8'h00, 8'h10, 8'd1);
        wait_done("t1", 200);
        chk("t1_wr_cnt",    64'(wr_log.size() - wb), 64'd1);
        chk("t1_wr_addr",   64'(wr_log[wb]), 64'h10);
        chk("t1_y_near0",   64'(count_big(wd_log[wb], 16)), 64'd0);
        chk("t1_done_cnt",  64'(job_done_cnt - jb), 64'd1);
        chk("t1_rows_done", 64'(bus.rows_done), 64'd1);

        // Four rows with alternating element patterns.
        for (int r = 0; r < 4; r++)
            xmem[4 + r] = (r % 2 == 0) ? alt_row(16'h0800, 16'h0200) : alt_row(16'h0200, 16'h0800);
        snap();
        send_cmd("t2", 8'h04, 8'h20, 8'd4);
        wait_done("t2", 400);
        chk("t2_wr_cnt", 64'(wr_log.size() - wb), 64'd4);
        for (int r = 0; r < 4; r++) begin
            chk($sformatf("t2_wr_addr%0d", r), 64'(wr_log[wb + r]), 64'(8'h20 + r));
            chk($sformatf("t2_y_bad%0d", r),
                64'(count_diff(wd_log[wb + r], (r % 2 == 0) ? y_a : y_b)), 64'd0);
        end
        chk("t2_rows_done",  64'(bus.rows_done), 64'd4);
        chk("t2_ln_starts",  64'(ln_start_cnt - lb), 64'd4);

        // Zero-row job: job_done two cycles after the cmd is presented.
        snap();
        bus.cmd_valid    = 1'b1;
        bus.cmd_src_base = 8'h30;
        bus.cmd_dst_base = 8'h40;
        bus.cmd_num_rows = 8'd0;
        n = 0;
        do begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            n++;
        end while (!bus.job_done && n < 10);
        chk("t3_done_lat", 64'(n), 64'd2);
        repeat (3) @(negedge clk);
        chk("t3_rd_cnt",    64'(rd_log.size() - rb), 64'd0);
        chk("t3_ln_starts", 64'(ln_start_cnt - lb), 64'd0);
        chk("t3_wr_cnt",    64'(wr_log.size() - wb), 64'd0);
        chk("t3_rows_done", 64'(bus.rows_done), 64'd0);

        // Address wrap on both buffers.
        xmem[8'hFE] = alt_row(16'h0100, 16'h0100);
        xmem[8'hFF] = alt_row(16'h0100, 16'h0100);
        snap();
        send_cmd("t4", 8'hFE, 8'hFF, 8'd3);
        wait_done("t4", 400);
        chk("t4_rd0", 64'(rd_log[rb + 0]), 64'hFE);
        chk("t4_rd1", 64'(rd_log[rb + 1]), 64'hFF);
        chk("t4_rd2", 64'(rd_log[rb + 2]), 64'h00);
        chk("t4_wr0", 64'(wr_log[wb + 0]), 64'hFF);
        chk("t4_wr1", 64'(wr_log[wb + 1]), 64'h00);
        chk("t4_wr2", 64'(wr_log[wb + 2]), 64'h01);
        chk("t4_rows_done", 64'(bus.rows_done), 64'd3);

        // Write back-pressure for 20 cycles.
        xmem[8] = alt_row(16'h0800, 16'h0200);
        bus.wr_ready = 1'b0;
        snap();
        send_cmd("t5", 8'h08, 8'h28, 8'd1);
        n = 0;
        while (!bus.wr_en && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_wr_en_seen", 64'(bus.wr_en), 64'd1);
        sa = bus.wr_addr;
        sd = bus.wr_data;
        chk("t5_stall_addr", 64'(sa), 64'h28);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("t5_stable%0d", c),
                64'({bus.wr_en, bus.wr_addr == sa, bus.wr_data == sd}), 64'b111);
        end
        chk("t5_no_early_wr", 64'(wr_log.size() - wb), 64'd0);
        bus.wr_ready = 1'b1;
        wait_done("t5", 50);
        chk("t5_wr_cnt", 64'(wr_log.size() - wb), 64'd1);
        chk("t5_y_bad",  64'(count_diff(wd_log[wb], y_a)), 64'd0);

        // LN never completes: timeout after TIMEOUT_CYC cycles in LN_WAIT.
        ln_done_en = 1'b0;
        snap();
        send_cmd("t6", 8'h00, 8'h32, 8'd2);
        n = 0;
        while (!bus.ln_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_ln_start_seen", 64'(bus.ln_start), 64'd1);
        n = 0;
        while (!bus.timeout_err && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_tmo_cycles", 64'(n), 64'(TIMEOUT_CYC));
        wait_done("t6", 10);
        chk("t6_timeout_err", 64'(bus.timeout_err), 64'd1);
        chk("t6_rows_done",   64'(bus.rows_done), 64'd0);
        chk("t6_wr_cnt",      64'(wr_log.size() - wb), 64'd0);
        chk("t6_ln_starts",   64'(ln_start_cnt - lb), 64'd1);
        chk("t6_done_cnt",    64'(job_done_cnt - jb), 64'd1);
        ln_done_en = 1'b1;
        send_cmd("t6b", 8'h00, 8'h3C, 8'd0);
        chk("t6b_tmo_cleared", 64'(bus.timeout_err), 64'd0);
        wait_done("t6b", 10);

        // Reset while waiting on LN drops the job.
        ln_lat = 40;
        snap();
        send_cmd("t7", 8'h00, 8'h46, 8'd1);
        n = 0;
        while (!bus.ln_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("t7_busy_pre", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset("t7");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        chk("t7_wr_cnt",   64'(wr_log.size() - wb), 64'd0);
        chk("t7_done_cnt", 64'(job_done_cnt - jb), 64'd0);
        chk("t7_idle",     64'(bus.cmd_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
